hssaer_tx_arb: RTL and testbench

HSSAER_TX_ARB -- requirements
Module: hssaer_tx_arb

---
 rtl/hssaer_tx_arb_pkg.sv | 10 +
 rtl/hssaer_rr_pick.sv | 27 ++
 rtl/hssaer_tx_arb.sv | 67 ++++++
 tb/tb_hssaer_tx_arb.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/hssaer_tx_arb_pkg.sv
// hssaer_tx_arb_pkg: shared defaults and tag-concatenation width rule for the HSSAER TX arbiter
package hssaer_tx_arb_pkg;
  localparam int def_dsize = 16;
  localparam int def_nch = 4;
  localparam int def_chw = 2;
  localparam int def_kaper = 1024;
  function automatic int pay_w(input int dsize, input int chw);
    return dsize - chw;
  endfunction
endpackage

// File: rtl/hssaer_rr_pick.sv
// hssaer_rr_pick: combinational round-robin picker searching upward from ptr+1 with wrap
module hssaer_rr_pick #(
  parameter int nch = 4,
  parameter int iw = 2
) (
  input  logic [nch-1:0] req,
  input  logic [iw-1:0]  ptr,
  output logic [nch-1:0] gnt,
  output logic [iw-1:0]  idx,
  output logic           any
);
  logic [iw-1:0] j;
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j = '0;
    for (int k = 1; k <= nch; k++) begin
      j = iw'((int'(ptr) + k) % nch);
      if (!any && req[j]) begin
        any = 1'b1;
        idx = j;
        gnt[j] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/hssaer_tx_arb.sv
// hssaer_tx_arb: round-robin merge of tagged channel events into one HSSAER transmitter, with keepalive
module hssaer_tx_arb
  import hssaer_tx_arb_pkg::*;
#(
  parameter int dsize = def_dsize,
  parameter int nch = def_nch,
  parameter int chw = def_chw,
  parameter int kaper = def_kaper
) (
  input  logic                          clkp,
  input  logic                          rst,
  input  logic [nch*pay_w(dsize,chw)-1:0] ch_ae,
  input  logic [nch-1:0]                ch_src_rdy,
  output logic [nch-1:0]                ch_dst_rdy,
  input  logic [nch-1:0]                ch_en,
  output logic [dsize-1:0]              ae,
  output logic                          src_rdy,
  input  logic                          dst_rdy,
  output logic                          keepalive,
  output logic                          busy
);
  localparam int aw = pay_w(dsize, chw);
  localparam int pw = $clog2(nch);
  localparam int kw = kaper > 0 ? $clog2(kaper + 1) : 1;
  logic [pw-1:0] ptr;
  logic [pw-1:0] idx;
  logic [nch-1:0] gnt;
  logic any;
  logic [kw-1:0] kcnt;
  logic load_ok;
  logic grant;
  assign load_ok = ~src_rdy | dst_rdy;
  assign ch_dst_rdy = (load_ok && !rst) ? gnt : '0;
  assign grant = |ch_dst_rdy;
  assign busy = src_rdy | |(ch_en & ch_src_rdy);
  hssaer_rr_pick #(.nch(nch), .iw(pw)) u_pick (
    .req(ch_en & ch_src_rdy),
    .ptr(ptr),
    .gnt(gnt),
    .idx(idx),
    .any(any)
  );
  always_ff @(posedge clkp) begin
    if (rst) begin
      src_rdy <= 1'b0;
      ae <= '0;
      ptr <= pw'(nch - 1);
      kcnt <= '0;
      keepalive <= 1'b0;
    end else begin
      if (grant) begin
        ae <= {chw'(idx), ch_ae[int'(idx)*aw +: aw]};
        src_rdy <= 1'b1;
        ptr <= idx;
      end else if (dst_rdy) begin
        src_rdy <= 1'b0;
      end
      keepalive <= 1'b0;
      if (kaper == 0 || grant) begin
        kcnt <= '0;
      end else if (!src_rdy) begin
        kcnt <= kcnt == kw'(kaper - 1) ? '0 : kcnt + 1'b1;
        keepalive <= kcnt == kw'(kaper - 1);
      end
    end
  end
endmodule

// File: tb/tb_hssaer_tx_arb.sv
// tb_hssaer_tx_arb: scoreboard bench for hssaer_tx_arb with a cycle model of grants, output and keepalive
module tb_hssaer_tx_arb;
  logic clkp = 1'b0;
  logic rst = 1'b1;
  logic [55:0] ch_ae;
  logic [3:0] ch_src_rdy = '0;
  logic [3:0] ch_dst_rdy;
  logic [3:0] ch_en = '0;
  logic [15:0] ae;
  logic src_rdy;
  logic dst_rdy = 1'b0;
  logic keepalive;
  logic busy;
  logic [13:0] pay [4];
  int n_chk = 0;
  int n_fail = 0;
  logic mon_en = 1'b0;
  logic [15:0] sb [$];
  int gq [$];
  logic m_src = 1'b0;
  int m_ptr = 3;
  int m_kc = 0;
  logic m_ka = 1'b0;
  always #5 clkp = ~clkp;
  always_comb for (int i = 0; i < 4; i++) ch_ae[i*14 +: 14] = pay[i];
  hssaer_tx_arb #(.dsize(16), .nch(4), .chw(2), .kaper(8)) dut (
    .clkp(clkp),
    .rst(rst),
    .ch_ae(ch_ae),
    .ch_src_rdy(ch_src_rdy),
    .ch_dst_rdy(ch_dst_rdy),
    .ch_en(ch_en),
    .ae(ae),
    .src_rdy(src_rdy),
    .dst_rdy(dst_rdy),
    .keepalive(keepalive),
    .busy(busy)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge clkp);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
  endtask
  always @(negedge clkp) begin
    logic [3:0] eg;
    int ej;
    logic old;
    eg = '0;
    ej = -1;
    if (!rst && (!m_src || dst_rdy))
      for (int k = 1; k <= 4; k++)
        if (ej < 0 && ch_en[(m_ptr + k) % 4] && ch_src_rdy[(m_ptr + k) % 4]) ej = (m_ptr + k) % 4;
    if (ej >= 0) eg[ej] = 1'b1;
    if (mon_en) begin
      check("m_src_rdy", 32'(src_rdy), 32'(m_src));
      check("m_grant", 32'(ch_dst_rdy), 32'(eg));
      check("m_keepalive", 32'(keepalive), 32'(m_ka));
      check("m_busy", 32'(busy), 32'(m_src | |(ch_en & ch_src_rdy)));
      if (src_rdy && dst_rdy && !rst) begin
        if (sb.size() == 0) check("sb_empty", 32'(ae), 32'hffff_ffff);
        else check("sb_ae", 32'(ae), 32'(sb.pop_front()));
      end
    end
    if (rst) begin
      m_src = 1'b0;
      m_ptr = 3;
      m_kc = 0;
      m_ka = 1'b0;
      sb.delete();
    end else begin
      old = m_src;
      if (ej >= 0) begin
        sb.push_back({2'(ej), pay[ej]});
        gq.push_back(ej);
        m_src = 1'b1;
        m_ptr = ej;
      end else if (dst_rdy) m_src = 1'b0;
      m_ka = 1'b0;
      if (ej >= 0) m_kc = 0;
      else if (!old) begin
        if (m_kc == 7) begin
          m_kc = 0;
          m_ka = 1'b1;
        end else m_kc++;
      end
    end
  end
  initial begin
    logic [15:0] a;
    logic [1:0] nt;
    logic got;
    for (int i = 0; i < 4; i++) pay[i] = 14'(14'h0123 * (i + 1));
    ch_en = 4'b1111;
    ch_src_rdy = 4'b1111;
    @(negedge clkp);
    check("rst_grant", 32'(ch_dst_rdy), 32'h0);
    ch_src_rdy = '0;
    do_reset();
    mon_en = 1'b1;
    @(negedge clkp);
    check("rst_ae", 32'(ae), 32'h0);
    check("rst_src_rdy", 32'(src_rdy), 32'h0);
    check("rst_keepalive", 32'(keepalive), 32'h0);
    @(posedge clkp);
    #1;
    gq.delete();
    dst_rdy = 1'b1;
    ch_src_rdy = 4'b1111;
    cyc(8);
    check("rr_count", 32'(gq.size()), 32'd8);
    for (int i = 0; i < 8 && i < gq.size(); i++) check("rr_order", 32'(gq[i]), 32'(i % 4));
    dst_rdy = 1'b0;
    a = ae;
    for (int i = 0; i < 5; i++) begin
      @(negedge clkp);
      check("stall_ae", 32'(ae), 32'(a));
      check("stall_grant", 32'(ch_dst_rdy), 32'h0);
    end
    @(posedge clkp);
    #1;
    dst_rdy = 1'b1;
    cyc(1);
    nt = a[15:14] + 2'd1;
    check("reload_src_rdy", 32'(src_rdy), 32'h1);
    check("reload_tag", 32'(ae[15:14]), 32'(nt));
    ch_src_rdy = '0;
    do_reset();
    pay[2] = 14'h1ABC;
    ch_src_rdy = 4'b0100;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clkp);
      got = ch_dst_rdy[2];
    end
    check("ch2_grant_seen", 32'(got), 32'h1);
    @(posedge clkp);
    #1;
    ch_src_rdy = '0;
    @(negedge clkp);
    check("ch2_ae", 32'(ae), 32'h9ABC);
    check("ch2_src_rdy", 32'(src_rdy), 32'h1);
    @(negedge clkp);
    check("ch2_hold_ae", 32'(ae), 32'h9ABC);
    check("ch2_drained", 32'(src_rdy), 32'h0);
    do_reset();
    gq.delete();
    ch_en = 4'b1010;
    ch_src_rdy = 4'b1111;
    cyc(6);
    check("en_count", 32'(gq.size()), 32'd6);
    for (int i = 0; i < 6 && i < gq.size(); i++) check("en_order", 32'(gq[i]), 32'(i % 2 ? 3 : 1));
    ch_src_rdy = '0;
    cyc(2);
    dst_rdy = 1'b0;
    ch_en = 4'b0010;
    ch_src_rdy = 4'b0010;
    cyc(1);
    ch_en = '0;
    ch_src_rdy = '0;
    cyc(2);
    @(negedge clkp);
    check("dis_src_rdy", 32'(src_rdy), 32'h1);
    check("dis_tag", 32'(ae[15:14]), 32'h1);
    @(posedge clkp);
    #1;
    dst_rdy = 1'b1;
    ch_en = 4'b1111;
    do_reset();
    for (int c = 0; c <= 26; c++) begin
      @(negedge clkp);
      check("ka_idle", 32'(keepalive), 32'(c != 0 && c % 8 == 0));
      @(posedge clkp);
      #1;
    end
    do_reset();
    for (int c = 0; c <= 22; c++) begin
      if (c == 4) ch_src_rdy = 4'b0001;
      if (c == 5) ch_src_rdy = '0;
      @(negedge clkp);
      check("ka_delay", 32'(keepalive), 32'(c == 14 || c == 22));
      @(posedge clkp);
      #1;
    end
    do_reset();
    dst_rdy = 1'b0;
    ch_src_rdy = 4'b0010;
    cyc(2);
    ch_src_rdy = '0;
    @(negedge clkp);
    check("pre_rst_src_rdy", 32'(src_rdy), 32'h1);
    do_reset();
    check("mid_rst_src_rdy", 32'(src_rdy), 32'h0);
    check("mid_rst_ae", 32'(ae), 32'h0);
    dst_rdy = 1'b1;
    cyc(2);
    check("post_rst_quiet", 32'(src_rdy), 32'h0);
    gq.delete();
    ch_src_rdy = 4'b1111;
    cyc(1);
    check("post_rst_first", 32'(gq.size() > 0 ? gq[0] : -1), 32'h0);
    ch_src_rdy = '0;
    cyc(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
